// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that samples each bit at its centre and hands bytes over with a valid/read handshake.
// Ports: clk system clock; rst async active-high reset; rx serial line (async to clk, idle high);
//        rx_rd one-cycle read strobe; rx_data last received byte; rx_vld unread byte pending;
//        frame_err one-cycle pulse on a 0 stop bit; overrun one-cycle pulse when a byte is dropped.
module uart_rx #(
    parameter logic [9:0] DIV_CNT  = 10'd867,
    parameter logic [9:0] HDIV_CNT = 10'd433
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       frame_err,
    output logic       overrun
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    logic       sync_q, rx_s_q, rx_p_q;
    logic [1:0] state_q, state_d;
    logic [9:0] div_q, div_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       vld_q, vld_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic       div_end, stop_ok, stop_bad, load;
    always_comb begin
        div_end  = div_q == DIV_CNT;
        state_d  = state_q;
        div_d    = div_end ? 10'd0 : div_q + 10'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = 10'd0;
                // Falling edge only, so a held-low line never restarts a frame.
                if (!rx_s_q && rx_p_q) state_d = START;
            end
            START: if (div_q == HDIV_CNT) begin
                state_d = rx_s_q ? IDLE : DATA;
                div_d   = 10'd0;
                bit_d   = 4'd0;
            end
            DATA: if (div_end) begin
                shift_d = {rx_s_q, shift_q[7:1]};
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'd7) state_d = STOP;
            end
            default: if (div_end) begin
                // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                state_d  = IDLE;
                stop_ok  = rx_s_q;
                stop_bad = !rx_s_q;
            end
        endcase
        load   = stop_ok && (!vld_q || rx_rd);
        data_d = load ? shift_q : data_q;
        vld_d  = load || (vld_q && !rx_rd);
        ferr_d = stop_bad;
        ovr_d  = stop_ok && !load;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            state_q <= IDLE;
            div_q   <= 10'd0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= rx;
            rx_s_q  <= sync_q;
            rx_p_q  <= rx_s_q;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign rx_data   = data_q;
    assign rx_vld    = vld_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 16 clk per bit.
module tb_uart_rx;
    logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_vld, frame_err, overrun;
    int         tests = 0, fails = 0;
    int         ferr_n = 0, ovr_n = 0, load_n = 0;
    logic       vld_p = 1'b0;
    int         f0, o0, l0;

    uart_rx #(.DIV_CNT(10'd15), .HDIV_CNT(10'd7)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_vld(rx_vld), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Count high cycles of the pulses and rising edges of rx_vld.
    always @(negedge clk) begin
        if (frame_err) ferr_n++;
        if (overrun) ovr_n++;
        if (rx_vld && !vld_p) load_n++;
        vld_p = rx_vld;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         rd_at;
        logic       rd_after;
        int         post_low;
        int         post_idle;
        logic [7:0] e_data;
        logic       e_vld;
        int         e_loads;
        int         e_ferr;
        int         e_ovr;
    } vec_t;
    vec_t v [8];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 160-cycle frame; rx_rd is high during frame cycle rd_at (sampled on the next edge).
    task automatic send(input logic [7:0] d, input logic stop, input int rd_at);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 160; k++) begin
            rx    = f[k/16];
            rx_rd = (k == rd_at);
            tick();
        end
        rx_rd = 1'b0;
    endtask

    task automatic snap();
        f0 = ferr_n;
        o0 = ovr_n;
        l0 = load_n;
    endtask

    initial begin
        //        d      stop  rd_at rd_af low idle  e_data e_vld ld fe ov
        v[0] = '{8'hA5, 1'b1, -1,  1'b1, 0,  0,   8'hA5, 1'b1, 1, 0, 0};
        v[1] = '{8'h00, 1'b1, 156, 1'b0, 0,  0,   8'h00, 1'b0, 1, 0, 0};
        v[2] = '{8'hFF, 1'b1, 156, 1'b0, 0,  0,   8'hFF, 1'b0, 1, 0, 0};
        v[3] = '{8'h3C, 1'b0, -1,  1'b0, 40, 200, 8'hFF, 1'b0, 0, 1, 0};
        v[4] = '{8'h11, 1'b1, -1,  1'b0, 0,  0,   8'h11, 1'b1, 1, 0, 0};
        v[5] = '{8'h22, 1'b1, -1,  1'b1, 0,  0,   8'h11, 1'b1, 0, 0, 1};
        v[6] = '{8'h11, 1'b1, -1,  1'b0, 0,  0,   8'h11, 1'b1, 1, 0, 0};
        v[7] = '{8'h22, 1'b1, 154, 1'b1, 0,  0,   8'h22, 1'b1, 0, 0, 0};

        #2 rst = 1'b1;
        #1;
        check("reset rx_data", {24'd0, rx_data}, 32'h00);
        check("reset rx_vld", {31'd0, rx_vld}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 8; i++) begin
            snap();
            send(v[i].d, v[i].stop, v[i].rd_at);
            if (v[i].post_low > 0) begin
                rx = 1'b0;
                repeat (v[i].post_low) tick();
            end
            if (v[i].post_idle > 0) begin
                rx = 1'b1;
                repeat (v[i].post_idle) tick();
            end
            check($sformatf("vec%0d rx_data", i), {24'd0, rx_data}, {24'd0, v[i].e_data});
            check($sformatf("vec%0d rx_vld", i), {31'd0, rx_vld}, {31'd0, v[i].e_vld});
            check($sformatf("vec%0d loads", i), load_n - l0, v[i].e_loads);
            check($sformatf("vec%0d frame_err cycles", i), ferr_n - f0, v[i].e_ferr);
            check($sformatf("vec%0d overrun cycles", i), ovr_n - o0, v[i].e_ovr);
            if (v[i].rd_after) begin
                rx_rd = 1'b1;
                tick();
                rx_rd = 1'b0;
                check($sformatf("vec%0d rx_vld after read", i), {31'd0, rx_vld}, 32'd0);
            end
        end

        // Short low glitch on an idle line must be rejected at the start-bit centre.
        snap();
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (200) tick();
        check("glitch rx_data", {24'd0, rx_data}, 32'h22);
        check("glitch rx_vld", {31'd0, rx_vld}, 32'd0);
        check("glitch loads", load_n - l0, 32'd0);
        check("glitch frame_err", ferr_n - f0, 32'd0);
        check("glitch overrun", ovr_n - o0, 32'd0);

        // Reset in the middle of frame 0x5A (after its 4th data bit).
        rx = 1'b0;
        repeat (16) tick();
        for (int b = 0; b < 4; b++) begin
            rx = (8'h5A >> b) & 8'h01;
            repeat (16) tick();
        end
        rx = 1'b1;
        repeat (4) tick();
        #3 rst = 1'b1;
        #1;
        check("midframe reset rx_data", {24'd0, rx_data}, 32'h00);
        check("midframe reset rx_vld", {31'd0, rx_vld}, 32'd0);
        check("midframe reset frame_err", {31'd0, frame_err}, 32'd0);
        check("midframe reset overrun", {31'd0, overrun}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        snap();
        send(8'h81, 1'b1, -1);
        check("post-reset rx_data", {24'd0, rx_data}, 32'h81);
        check("post-reset rx_vld", {31'd0, rx_vld}, 32'd1);
        check("post-reset loads", load_n - l0, 32'd1);
        check("post-reset frame_err", ferr_n - f0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
